// File: rtl/bg_pkg.sv
// Shared types and geometry for the background index-RAM region writer.
package bg_pkg;

    localparam int RESHAPE_LENGTH = 320;
    localparam int RESHAPE_HEIGHT = 240;
    localparam int ADDR_W         = 19;
    localparam logic [3:0] TRANSPARENT_INDEX = 4'h0;

    typedef logic [3:0] palette_idx_t;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [8:0] w;
        logic [7:0] h;
    } region_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_BLANK,
        WRITE,
        DONE
    } bg_wr_state_t;

    // 10-bit sums so a right/bottom edge past the image cannot wrap back in range.
    function automatic logic region_bad(input region_t r);
        logic [9:0] xe;
        logic [9:0] ye;
        xe = {1'b0, r.x} + {1'b0, r.w};
        ye = {2'b0, r.y} + {2'b0, r.h};
        return (r.w == 9'd0) || (r.h == 8'd0) ||
               (xe > 10'(RESHAPE_LENGTH)) || (ye > 10'(RESHAPE_HEIGHT));
    endfunction

endpackage

// File: rtl/bg_region_addr_gen.sv
// Column/row walker for a rectangular region; produces the RAM address of the
// current pixel and flags the final pixel of the region.
module bg_region_addr_gen
    import bg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  region_t           region,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [8:0]        col_q, col_d;
    logic [7:0]        row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] y_ext;
    logic              col_end, row_end;

    assign y_ext   = ADDR_W'(region.y);
    assign col_end = (col_q == region.w - 9'd1);
    assign row_end = (row_q == region.h - 8'd1);
    assign addr    = row_base_q + ADDR_W'(col_q);
    assign last    = col_end && row_end;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        if (load) begin
            col_d      = 9'd0;
            row_d      = 8'd0;
            // y*320 as (y<<8)+(y<<6), avoiding a multiplier
            row_base_d = (y_ext << 8) + (y_ext << 6) + ADDR_W'(region.x);
        end else if (step) begin
            if (col_end) begin
                col_d      = 9'd0;
                row_d      = row_q + 8'd1;
                row_base_d = row_base_q + ADDR_W'(RESHAPE_LENGTH);
            end else begin
                col_d = col_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/bg_region_writer.sv
// Streams palette indices into a rectangle of the 320x240 index RAM during blank.
// Optional BG_REGION_TRANSPARENT_SKIP_EN: transparent pixels advance but are not written.
module bg_region_writer
    import bg_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [8:0]        rect_x,
    input  logic [7:0]        rect_y,
    input  logic [8:0]        rect_w,
    input  logic [7:0]        rect_h,
    input  logic              blank,
    input  logic [3:0]        pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_address,
    output logic [3:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    bg_wr_state_t      state_q, state_d;
    region_t           region_q;
    logic              wr_en_q, err_q;
    logic [ADDR_W-1:0] wr_address_q;
    palette_idx_t      wr_data_q;
    logic              accept, skip_px, last_px;
    logic [ADDR_W-1:0] gen_addr;

    assign pix_ready  = (state_q == WRITE) && blank;
    assign accept     = pix_valid && pix_ready;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign wr_en      = wr_en_q;
    assign wr_address = wr_address_q;
    assign wr_data    = wr_data_q;

`ifdef BG_REGION_TRANSPARENT_SKIP_EN
    assign skip_px = (pix_data == TRANSPARENT_INDEX);
`else
    assign skip_px = 1'b0;
`endif

    bg_region_addr_gen u_addr_gen (
        .clk    (Clk),
        .rst    (Reset),
        .load   (state_q == CHECK),
        .step   (accept),
        .region (region_q),
        .addr   (gen_addr),
        .last   (last_px)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = CHECK;
            CHECK:      state_d = region_bad(region_q) ? IDLE : WAIT_BLANK;
            WAIT_BLANK: if (blank) state_d = WRITE;
            WRITE:      if (accept && last_px) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            region_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start)
                region_q <= '{x: rect_x, y: rect_y, w: rect_w, h: rect_h};
            wr_en_q <= accept && !skip_px;
            if (accept) begin
                wr_address_q <= gen_addr;
                wr_data_q    <= pix_data;
            end
            err_q <= (state_q == CHECK) && region_bad(region_q);
        end
    end

endmodule

// File: tb/tb_bg_region_writer.sv
// Directed + randomized bench for bg_region_writer with a region-level address model.
module tb_bg_region_writer;
    import bg_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset, start, blank, pix_valid;
    logic [8:0]        rect_x, rect_w;
    logic [7:0]        rect_y, rect_h;
    logic [3:0]        pix_data;
    logic              pix_ready, wr_en, busy, done, err;
    logic [ADDR_W-1:0] wr_address;
    logic [3:0]        wr_data;

    int tests = 0;
    int fails = 0;
    int pat[$];
    bit skip_en;

    bg_region_writer dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .blank(blank), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .wr_en(wr_en), .wr_address(wr_address),
        .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_pix_ready"}, pix_ready, 0);
        check({tag, "_wr_address"}, wr_address, 0);
        check({tag, "_wr_data"}, wr_data, 0);
    endtask

    // Rejected region: err pulses two cycles after the start, nothing written.
    task automatic run_err(input int x, input int y, input int w, input int h);
        rect_x = 9'(x); rect_y = 8'(y); rect_w = 9'(w); rect_h = 8'(h);
        start = 1; pix_valid = 1; blank = 1;
        tick;
        start = 0;
        check("err_check_busy", busy, 1);
        check("err_check_err", err, 0);
        check("err_check_ready", pix_ready, 0);
        tick;
        check("err_pulse", err, 1);
        check("err_busy_clear", busy, 0);
        check("err_no_write", wr_en, 0);
        tick;
        check("err_one_cycle", err, 0);
        check("err_still_no_write", wr_en, 0);
        pix_valid = 0;
    endtask

    // bmode: 0 blank high, 1 blank toggles every 3 cycles, 2 random blank.
    task automatic run_region(input int x, input int y, input int w, input int h,
                              input int bmode, input bit rvalid,
                              input int reset_after, input int last_addr);
        int total = w * h;
        int k = 0;
        int cyc = 0;
        int pa = 0;
        int pd = 0;
        bit pend = 0;
        bit plast = 0;
        bit fin = 0;
        bit exp_we;
        rect_x = 9'(x); rect_y = 8'(y); rect_w = 9'(w); rect_h = 8'(h);
        start = 1;
        tick;
        while (cyc < 4 * total + 100) begin
            start = 0;
            check("busy", busy, 1);
            exp_we = pend && !(skip_en && pd == 0);
            check("wr_en", wr_en, exp_we);
            if (exp_we) begin
                check("wr_address", wr_address, pa);
                check("wr_data", wr_data, pd);
                if (plast && last_addr >= 0) check("last_addr", wr_address, last_addr);
            end
            check("done", done, pend && plast);
            if (pend && plast) begin
                check("ready_in_done", pix_ready, 0);
                fin = 1;
                break;
            end
            pend = 0;
            if (reset_after >= 0 && k == reset_after) begin
                Reset = 1; pix_valid = 0;
                tick;
                check_idle_outputs("mid_reset");
                Reset = 0;
                return;
            end
            if (cyc == 2) begin
                rect_x = 0; rect_y = 0; rect_w = 1; rect_h = 1; start = 1;
            end
            case (bmode)
                0: blank = 1;
                1: blank = ((cyc / 3) % 2) == 1;
                default: blank = $urandom_range(0, 3) != 0;
            endcase
            pix_valid = rvalid ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_data  = (k < pat.size()) ? 4'(pat[k]) : 4'($urandom_range(0, 15));
            #1;
            if (!blank) check("ready_gated_by_blank", pix_ready, 0);
            if (pix_valid && pix_ready) begin
                pa    = (y + k / w) * RESHAPE_LENGTH + x + (k % w);
                pd    = int'(pix_data);
                plast = (k == total - 1);
                pend  = 1;
                k++;
            end
            @(posedge Clk);
            #1;
            cyc++;
        end
        check("region_finished", fin, 1);
        check("pixels_accepted", k, total);
        pix_valid = 0;
        tick;
        check("after_busy", busy, 0);
        check("after_done", done, 0);
        check("after_wr_en", wr_en, 0);
        check("after_ready", pix_ready, 0);
    endtask

    initial begin
`ifdef BG_REGION_TRANSPARENT_SKIP_EN
        skip_en = 1;
`else
        skip_en = 0;
`endif
        Reset = 1; start = 0; blank = 0; pix_valid = 0; pix_data = 0;
        rect_x = 0; rect_y = 0; rect_w = 0; rect_h = 0;
        tick; tick;
        check_idle_outputs("reset");
        Reset = 0;
        tick;

        run_region(20, 3, 37, 6, 0, 0, -1, -1);
        run_err(300, 10, 30, 5);
        run_err(270, 0, 100, 48);
        run_err(5, 5, 0, 3);
        run_err(5, 5, 3, 0);
        run_err(0, 200, 10, 41);
        run_region(319, 239, 1, 1, 0, 0, -1, 76799);
        run_region(0, 0, 4, 2, 1, 0, -1, 323);
        for (int i = 0; i < 4; i++) begin
            int w = $urandom_range(1, 24);
            int h = $urandom_range(1, 6);
            run_region($urandom_range(0, 320 - w), $urandom_range(0, 240 - h), w, h, 2, 1, -1, -1);
        end
        run_region(5, 7, 4, 4, 0, 0, 10, -1);
        tick;
        run_region(5, 7, 4, 4, 0, 1, -1, 7 * 320 + 5 + 3 * 320 + 3);
        pat = '{0, 5, 0, 7};
        run_region(10, 10, 4, 1, 0, 0, -1, -1);
        pat.delete();
        run_region(0, 0, 320, 240, 0, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
